// File: rtl/spi_pkg.sv
// Shared SPI receive definitions.
//   SPI_WIDTH       default frame width in bits
//   spi_rx_state_t  receive FSM states
//   SPI_SCLK_IDLE   idle level of sclk (low)
//   SPI_CS_IDLE     idle level of cs (high, chip select is active low)
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 12;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_HOLD
    } spi_rx_state_t;

    localparam logic SPI_SCLK_IDLE = 1'b0;
    localparam logic SPI_CS_IDLE   = 1'b1;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI receive bus: serial lines from the master plus the parallel result.
//   sclk, cs, mosi   serial lines (master drives)
//   dout, done, busy receive result and status (slave drives)
//   frame_err        framing error pulse, present only with SPI_RX_ERR_EN
// Optional feature macro: SPI_RX_ERR_EN
interface spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
);

    logic             sclk;
    logic             cs;
    logic             mosi;
    logic [WIDTH-1:0] dout;
    logic             done;
    logic             busy;
`ifdef SPI_RX_ERR_EN
    logic             frame_err;

    modport master (output sclk, cs, mosi, input dout, done, busy, frame_err);
    modport slave  (input sclk, cs, mosi, output dout, done, busy, frame_err);
`else
    modport master (output sclk, cs, mosi, input dout, done, busy);
    modport slave  (input sclk, cs, mosi, output dout, done, busy);
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one history flop for edge detection.
//   clk, rst  system clock, synchronous active-high reset
//   line      asynchronous input
//   level     synchronized level
//   rise      level went 0 -> 1 this cycle
//   fall      level went 1 -> 0 this cycle
// On reset every flop loads IDLE_VAL so no spurious edge follows reset.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{IDLE_VAL}};
            hist  <= IDLE_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], line};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-side SPI stage. Oversamples sclk/cs/mosi on the system clock,
// rebuilds each LSB-first WIDTH-bit word and presents it on dout with a
// one-cycle done strobe.
//   clk, rst  system clock, synchronous active-high reset
//   bus       spi_slave_rx_if.slave: sclk/cs/mosi in; dout/done/busy out
//             (plus frame_err when SPI_RX_ERR_EN is defined)
// Optional feature macro: SPI_RX_ERR_EN adds a one-cycle frame_err pulse on
// a short frame (cs rises early) or a long frame (first excess sclk rise).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    spi_slave_rx_if.slave bus
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_VAL    (SPI_SCLK_IDLE)
    ) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (bus.sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_VAL    (SPI_CS_IDLE)
    ) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .line  (bus.cs),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Only the sclk rising edge matters; its level and falling edge are spare.
    logic unused_sclk;
    assign unused_sclk = sclk_level ^ sclk_fall;

    // mosi has the same depth as sclk so the sampled bit lines up with sclk_rise.
    logic [SYNC_STAGES-1:0] mosi_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    spi_rx_state_t    state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bitcnt;
    logic [WIDTH-1:0] next_word;
`ifdef SPI_RX_ERR_EN
    logic             long_seen;
`endif

    assign next_word = {mosi_s, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            bus.dout  <= '0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b0;
`ifdef SPI_RX_ERR_EN
            bus.frame_err <= 1'b0;
            long_seen     <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef SPI_RX_ERR_EN
            bus.frame_err <= 1'b0;
`endif
            case (state)
                // An sclk edge coinciding with cs_fall is deliberately not counted.
                RX_IDLE: begin
                    if (cs_fall) begin
                        state    <= RX_SHIFT;
                        bus.busy <= 1'b1;
                        bitcnt   <= '0;
                        shreg    <= '0;
`ifdef SPI_RX_ERR_EN
                        long_seen <= 1'b0;
`endif
                    end
                end

                RX_SHIFT: begin
                    if (cs_rise) begin
                        // Short frame: partial word discarded, dout untouched.
                        state    <= RX_IDLE;
                        bus.busy <= 1'b0;
`ifdef SPI_RX_ERR_EN
                        bus.frame_err <= 1'b1;
`endif
                    end else if (sclk_rise && !cs_s) begin
                        shreg  <= next_word;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == LAST_BIT) begin
                            bus.dout <= next_word;
                            bus.done <= 1'b1;
                            state    <= RX_HOLD;
                        end
                    end
                end

                RX_HOLD: begin
                    if (cs_rise) begin
                        state    <= RX_IDLE;
                        bus.busy <= 1'b0;
`ifdef SPI_RX_ERR_EN
                    end else if (sclk_rise && !long_seen) begin
                        bus.frame_err <= 1'b1;
                        long_seen     <= 1'b1;
`endif
                    end
                end

                default: begin
                    state    <= RX_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: reset hold, a table of directed
// frames, random frames against a word-level model, and hand-written
// reset-mid-frame / cs-with-sclk corner sequences.
// Honours SPI_RX_ERR_EN for the frame_err checks.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int unsigned WIDTH = SPI_WIDTH;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HALF  = 4;   // clk cycles per sclk phase
    localparam int unsigned GAP   = 8;   // clk cycles of cs high after a frame

    logic clk = 1'b0;
    logic rst;

    spi_slave_rx_if #(.WIDTH(WIDTH)) bus ();

    spi_slave_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle counter and output monitor.
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt  = 0;
    int unsigned done_cyc = 0;
    int unsigned rise_cyc = 0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_single_cycle", 32'(prev_done), 32'd0);
        end
        prev_done = bus.done;
`ifdef SPI_RX_ERR_EN
        if (bus.frame_err === 1'b1) err_cnt++;
`endif
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master: cs low, nbits LSB-first bits, cs high, idle gap.
    // glitch raises sclk together with cs so that edge must not count.
    task automatic send_frame(input logic [15:0] data, input int unsigned nbits, input logic glitch);
        bus.cs = 1'b0;
        if (glitch) begin
            bus.mosi = 1'b1;
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
        tick(HALF);
        for (int i = 0; i < int'(nbits); i++) begin
            bus.mosi = data[i];
            tick(HALF);
            bus.sclk = 1'b1;
            if (i == int'(WIDTH) - 1) rise_cyc = cyc;
            tick(HALF);
            bus.sclk = 1'b0;
        end
        tick(HALF);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        bus.cs = 1'b1;
        tick(GAP);
    endtask

    // Word-level reference: a frame completes iff at least WIDTH bits arrive;
    // the word is the first WIDTH bits, bit i weighted 2**i.
    logic [WIDTH-1:0] last_dout;

    task automatic model(input logic [15:0] data, input int unsigned nbits,
                         output logic exp_done, output logic [WIDTH-1:0] exp_dout,
                         output logic exp_err);
        int unsigned word;
        word = 0;
        for (int unsigned i = 0; i < WIDTH; i++)
            if (i < nbits && data[i]) word = word + (32'd1 << i);
        exp_done = (nbits >= WIDTH);
        exp_err  = (nbits != WIDTH);
        exp_dout = exp_done ? WIDTH'(word) : last_dout;
    endtask

    task automatic run_frame(input logic [15:0] data, input int unsigned nbits, input logic glitch,
                             input logic exp_done, input logic [WIDTH-1:0] exp_dout,
                             input logic exp_err);
        int unsigned d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(data, nbits, glitch);
        check("done_count", done_cnt - d0, 32'(exp_done));
        if (exp_done)
            check("done_latency_ok", 32'((done_cyc - rise_cyc) >= SYNC && (done_cyc - rise_cyc) <= SYNC + 4), 32'd1);
        check("dout", 32'(bus.dout), 32'(exp_dout));
        check("busy_after_cs", 32'(bus.busy), 32'd0);
`ifdef SPI_RX_ERR_EN
        check("frame_err_count", err_cnt - e0, 32'(exp_err));
`else
        if (exp_err) check("no_err_port_idle_busy", 32'(bus.busy), 32'd0);
`endif
        last_dout = exp_dout;
    endtask

    typedef struct {
        logic [15:0]      data;
        int unsigned      nbits;
        logic             glitch;
        logic             exp_done;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic             m_done, m_err;
        logic [WIDTH-1:0] m_dout;
        logic [15:0]      rdata;
        int unsigned      rbits;
        int unsigned      d0, e0;

        vecs[0] = '{16'h095C, 12, 1'b0, 1'b1, 12'h95C, 1'b0};
        vecs[1] = '{16'h0A5A, 12, 1'b0, 1'b1, 12'hA5A, 1'b0};
        vecs[2] = '{16'h00F0, 12, 1'b0, 1'b1, 12'h0F0, 1'b0};
        vecs[3] = '{16'h007F,  7, 1'b0, 1'b0, 12'h0F0, 1'b1};
        vecs[4] = '{16'h3123, 14, 1'b0, 1'b1, 12'h123, 1'b1};
        vecs[5] = '{16'h0555, 12, 1'b1, 1'b1, 12'h555, 1'b0};
        vecs[6] = '{16'h0800, 12, 1'b0, 1'b1, 12'h800, 1'b0};
        vecs[7] = '{16'h07FF, 11, 1'b0, 1'b0, 12'h800, 1'b1};
        vecs[8] = '{16'h1ABC, 13, 1'b0, 1'b1, 12'hABC, 1'b1};
        vecs[9] = '{16'h0001, 12, 1'b0, 1'b1, 12'h001, 1'b0};

        // Reset held for 100 clk with idle lines.
        rst      = 1'b1;
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("rst_dout", 32'(bus.dout), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SPI_RX_ERR_EN
            check("rst_frame_err", 32'(bus.frame_err), 32'd0);
`endif
        end
        tick(1);
        rst = 1'b0;
        last_dout = '0;
        tick(GAP);

        // Directed table.
        for (int i = 0; i < 10; i++)
            run_frame(vecs[i].data, vecs[i].nbits, vecs[i].glitch,
                      vecs[i].exp_done, vecs[i].exp_dout, vecs[i].exp_err);

        // Random frames against the reference model.
        for (int i = 0; i < 40; i++) begin
            rdata = 16'($urandom);
            rbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : WIDTH;
            model(rdata, rbits, m_done, m_dout, m_err);
            run_frame(rdata, rbits, 1'b0, m_done, m_dout, m_err);
        end

        // Reset after 5 bits of a frame: partial word lost, no done.
        d0 = done_cnt;
        e0 = err_cnt;
        bus.cs = 1'b0;
        tick(HALF);
        for (int i = 0; i < 5; i++) begin
            bus.mosi = 1'b1;
            tick(HALF);
            bus.sclk = 1'b1;
            tick(HALF);
            bus.sclk = 1'b0;
        end
        tick(HALF);
        rst    = 1'b1;
        bus.cs = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_dout", 32'(bus.dout), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        tick(GAP);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_no_err", err_cnt - e0, 32'd0);
        last_dout = '0;
        run_frame(16'h0FFF, 12, 1'b0, 1'b1, 12'hFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
